// File: rtl/qam16_pkg.sv
// Shared constants, level/dibit mapping and slicer for the 16-QAM receiver.
// Decision boundaries sit midway between the ideal +/-1 and +/-3 correlation sums.
package qam16_pkg;
  localparam int IN_W     = 13;
  localparam int CW_W     = 10;
  localparam int CARR_LEN = 16;
  localparam int SYM_LEN  = 64;
  localparam int ACC_W    = 30;
  localparam int PROD_W   = IN_W + CW_W;

  localparam logic signed [ACC_W-1:0] THRESH  = 30'sd16711744;
  localparam logic signed [ACC_W-1:0] NTHRESH = -THRESH;

  localparam logic signed [2:0] LVL_M3 = -3'sd3;
  localparam logic signed [2:0] LVL_M1 = -3'sd1;
  localparam logic signed [2:0] LVL_P1 = 3'sd1;
  localparam logic signed [2:0] LVL_P3 = 3'sd3;

  typedef enum logic {IDLE, RUN} state_t;

  // Exact ties land on the upper level.
  function automatic logic signed [2:0] slice_lvl(input logic signed [ACC_W-1:0] s);
    if (s >= THRESH)       return LVL_P3;
    else if (!s[ACC_W-1])  return LVL_P1;
    else if (s >= NTHRESH) return LVL_M1;
    else                   return LVL_M3;
  endfunction

  function automatic logic [1:0] lvl2dibit(input logic signed [2:0] l);
    case (l)
      LVL_P3:  return 2'b11;
      LVL_P1:  return 2'b10;
      LVL_M1:  return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic signed [2:0] dibit2lvl(input logic [1:0] d);
    case (d)
      2'b11:   return LVL_P3;
      2'b10:   return LVL_P1;
      2'b01:   return LVL_M1;
      default: return LVL_M3;
    endcase
  endfunction
endpackage

// File: rtl/qam_carrier_lut.sv
// Combinational cos/sin ROM, 16 points per period, amplitude 511.
// sin is read from the cos table a quarter period back.
module qam_carrier_lut import qam16_pkg::*; (
  input  logic [$clog2(CARR_LEN)-1:0] phase,
  output logic signed [CW_W-1:0]      cos_w,
  output logic signed [CW_W-1:0]      sin_w
);
  localparam int PH_W = $clog2(CARR_LEN);

  function automatic logic signed [CW_W-1:0] cos_tab(input logic [PH_W-1:0] k);
    case (k)
      4'd0:    return  10'sd511;
      4'd1:    return  10'sd472;
      4'd2:    return  10'sd361;
      4'd3:    return  10'sd196;
      4'd4:    return  10'sd0;
      4'd5:    return -10'sd196;
      4'd6:    return -10'sd361;
      4'd7:    return -10'sd472;
      4'd8:    return -10'sd511;
      4'd9:    return -10'sd472;
      4'd10:   return -10'sd361;
      4'd11:   return -10'sd196;
      4'd12:   return  10'sd0;
      4'd13:   return  10'sd196;
      4'd14:   return  10'sd361;
      default: return  10'sd472;
    endcase
  endfunction

  assign cos_w = cos_tab(phase);
  assign sin_w = cos_tab(phase - PH_W'(CARR_LEN/4));
endmodule

// File: rtl/qam16_demodulator.sv
// Coherent 16-QAM receiver: per-rail integrate-and-dump correlators, 4-level slicer
// and a 4-bit MSB-first serializer clocked by the sample strobe.
module qam16_demodulator import qam16_pkg::*; (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_en,
  input  logic signed [IN_W-1:0] rx_in,
  input  logic                   sym_sync,
  output logic [1:0]             SigI,
  output logic [1:0]             SigQ,
  output logic signed [2:0]      Siga,
  output logic signed [2:0]      Sigb,
  output logic                   sym_valid,
  output logic                   bit_out,
  output logic                   bit_valid,
  output logic                   lock
);
  localparam int NUM_RAILS = 2;
  localparam int PH_W      = $clog2(CARR_LEN);
  localparam int SC_W      = $clog2(SYM_LEN);
  localparam int DIV_W     = $clog2(SYM_LEN/4);

  state_t                           state, state_nx;
  logic [PH_W-1:0]                  phase, lut_ph;
  logic [SC_W-1:0]                  scnt;
  logic [NUM_RAILS-1:0][CW_W-1:0]   coef;
  logic [NUM_RAILS-1:0][PROD_W-1:0] prod;
  logic [NUM_RAILS-1:0][ACC_W-1:0]  pext, acc, sum;
  logic [NUM_RAILS-1:0][2:0]        lvl;
  logic [NUM_RAILS-1:0][1:0]        dib;
  logic                             sync_hit, run_hit, sym_end;
  logic [2:0]                       sh;
  logic [1:0]                       pend;
  logic [DIV_W-1:0]                 div;

  assign sync_hit = sample_en & sym_sync;
  assign run_hit  = sample_en & ~sym_sync & (state == RUN);
  assign sym_end  = run_hit & (scnt == SC_W'(SYM_LEN-1));
  // A sync sample is always n=0, even when it interrupts a symbol.
  assign lut_ph   = sync_hit ? '0 : phase;

  qam_carrier_lut u_lut (.phase(lut_ph), .cos_w(coef[0]), .sin_w(coef[1]));

  for (genvar r = 0; r < NUM_RAILS; r++) begin : g_rail
    logic signed [PROD_W-1:0] rx_ext, cw_ext;
    assign rx_ext  = {{CW_W{rx_in[IN_W-1]}}, rx_in};
    assign cw_ext  = {{IN_W{coef[r][CW_W-1]}}, coef[r]};
    assign prod[r] = rx_ext * cw_ext;
    assign pext[r] = {{(ACC_W-PROD_W){prod[r][PROD_W-1]}}, prod[r]};
    assign sum[r]  = acc[r] + pext[r];
    assign lvl[r]  = slice_lvl(sum[r]);
    assign dib[r]  = lvl2dibit(lvl[r]);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sync_hit) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      scnt      <= '0;
      acc       <= '0;
      SigI      <= '0;
      SigQ      <= '0;
      Siga      <= '0;
      Sigb      <= '0;
      sym_valid <= 1'b0;
      lock      <= 1'b0;
    end else begin
      state     <= state_nx;
      sym_valid <= 1'b0;
      if (sync_hit) begin
        acc   <= pext;
        phase <= PH_W'(1);
        scnt  <= SC_W'(1);
      end else if (run_hit) begin
        phase <= phase + PH_W'(1);
        if (sym_end) begin
          acc       <= '0;
          scnt      <= '0;
          SigI      <= dib[0];
          SigQ      <= dib[1];
          Siga      <= lvl[0];
          Sigb      <= lvl[1];
          sym_valid <= 1'b1;
          lock      <= 1'b1;
        end else begin
          acc  <= sum;
          scnt <= scnt + SC_W'(1);
        end
      end
    end
  end

  // Serializer: load on symbol end, then one shift per SYM_LEN/4 strobes, three shifts max.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh        <= '0;
      pend      <= '0;
      div       <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      if (sym_end) begin
        sh        <= {dib[0][0], dib[1]};
        bit_out   <= dib[0][1];
        bit_valid <= 1'b1;
        pend      <= 2'd3;
        div       <= '0;
      end else if (sync_hit) begin
        div <= '0;
      end else if (sample_en) begin
        if (div == DIV_W'(SYM_LEN/4-1)) begin
          div <= '0;
          if (pend != 2'd0) begin
            bit_out   <= sh[2];
            sh        <= {sh[1:0], 1'b0};
            bit_valid <= 1'b1;
            pend      <= pend - 2'd1;
          end
        end else begin
          div <= div + DIV_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_qam16_demodulator.sv
// Scoreboard bench for qam16_demodulator: synthesizes x[n]=a*cos+b*sin from its own table.
module tb_qam16_demodulator;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample_en = 1'b0;
  logic              sym_sync = 1'b0;
  logic signed [12:0] rx_in = '0;
  logic [1:0]        SigI, SigQ;
  logic signed [2:0] Siga, Sigb;
  logic              sym_valid, bit_out, bit_valid, lock;

  int compared = 0;
  int mismatched = 0;
  int en_cnt = 0;
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  int         obs_en_q[$];
  logic       bits_q[$];
  int         bits_en_q[$];
  int ctab[16] = '{511, 472, 361, 196, 0, -196, -361, -472,
                   -511, -472, -361, -196, 0, 196, 361, 472};
  int lvls[4] = '{-3, -1, 1, 3};

  always #5 clk = ~clk;

  qam16_demodulator dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .rx_in(rx_in), .sym_sync(sym_sync),
    .SigI(SigI), .SigQ(SigQ), .Siga(Siga), .Sigb(Sigb), .sym_valid(sym_valid),
    .bit_out(bit_out), .bit_valid(bit_valid), .lock(lock)
  );

  function automatic logic signed [12:0] rx_val(input int a, input int b, input int p);
    return 13'(a * ctab[p] + b * ctab[(p + 12) % 16]);
  endfunction

  function automatic logic [1:0] dib(input int a);
    case (a)
      3:       return 2'b11;
      1:       return 2'b10;
      -1:      return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [9:0] exp_word(input int a, input int b);
    logic [2:0] la, lb;
    la = 3'(a);
    lb = 3'(b);
    return {dib(a), dib(b), la, lb};
  endfunction

  // One clock: drive, take the edge, record what the DUT reports.
  task automatic step(input logic en, input logic sy, input logic signed [12:0] x);
    sample_en = en;
    sym_sync  = sy;
    rx_in     = x;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    sym_sync  = 1'b0;
    if (en) en_cnt++;
    if (sym_valid) begin
      obs_q.push_back({SigI, SigQ, Siga, Sigb});
      obs_en_q.push_back(en_cnt);
    end
    if (bit_valid) begin
      bits_q.push_back(bit_out);
      bits_en_q.push_back(en_cnt);
    end
  endtask

  task automatic send_sym(input int a, input int b, input logic sync, input logic gaps, input int nsamp);
    for (int n = 0; n < nsamp; n++) begin
      step(1'b1, sync && (n == 0), rx_val(a, b, n % 16));
      if (gaps && $urandom_range(0, 2) == 0) step(1'b0, 1'b0, 13'sd0);
    end
    if (nsamp == 64) exp_q.push_back(exp_word(a, b));
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 2; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 13'($urandom_range(0, 2000)));
    compared++;
    if ({SigI, SigQ, Siga, Sigb, sym_valid, bit_out, bit_valid, lock} !== 14'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h want 0", {SigI, SigQ, Siga, Sigb, sym_valid, bit_out, bit_valid, lock});
    end
    rst = 1'b0;
    obs_q.delete(); obs_en_q.delete(); bits_q.delete(); bits_en_q.delete();
    for (int i = 0; i < 70; i++) step(1'b1, 1'b0, 13'($urandom_range(0, 2000)));
    compared++;
    if (obs_q.size() != 0 || lock !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_no_sync: sym_valid count %0d lock %b want 0 / 0", obs_q.size(), lock);
    end
  endtask

  task automatic test_single;
    logic [9:0] e, o;
    send_sym(3, -1, 1'b1, 1'b0, 64);
    compared++;
    if (sym_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL single_latency: sym_valid %b want 1", sym_valid);
    end
    compared++;
    if ({SigI, SigQ, Siga, Sigb} !== {2'b11, 2'b01, 3'sd3, -3'sd1}) begin
      mismatched++;
      $display("FAIL single_data: got %h want %h", {SigI, SigQ, Siga, Sigb}, {2'b11, 2'b01, 3'sd3, -3'sd1});
    end
    compared++;
    if (lock !== 1'b1) begin
      mismatched++;
      $display("FAIL single_lock: got %b want 1", lock);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_en_q.pop_front());
      compared++;
      if (o !== e) begin mismatched++; $display("FAIL single_sb: got %h want %h", o, e); end
    end
    step(1'b0, 1'b0, 13'sd0);
    compared++;
    if (sym_valid !== 1'b0 || Siga !== 3'sd3) begin
      mismatched++;
      $display("FAIL single_hold: sym_valid %b Siga %0d want 0 / 3", sym_valid, Siga);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] e, o;
    exp_q.delete(); obs_q.delete(); obs_en_q.delete();
    for (int i = 0; i < 16; i++) send_sym(lvls[i / 4], lvls[i % 4], i == 0, 1'b0, 64);
    compared++;
    if (obs_q.size() != 16) begin
      mismatched++;
      $display("FAIL b2b_count: got %0d want 16", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_en_q.pop_front());
      compared++;
      if (o !== e) begin mismatched++; $display("FAIL b2b_sym: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete(); obs_en_q.delete();
  endtask

  task automatic test_serial;
    int k;
    logic want[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    send_sym(1, -1, 1'b1, 1'b1, 64);
    k = bits_q.size() - 1;
    send_sym(3, 3, 1'b0, 1'b1, 64);
    compared++;
    if (k < 0 || bits_q.size() - k != 5) begin
      mismatched++;
      $display("FAIL serial_pulses: got %0d want 5", bits_q.size() - k);
    end else begin
      for (int i = 0; i < 4; i++) begin
        compared++;
        if (bits_q[k + i] !== want[i]) begin
          mismatched++;
          $display("FAIL serial_bit%0d: got %b want %b", i, bits_q[k + i], want[i]);
        end
        compared++;
        if (bits_en_q[k + i + 1] - bits_en_q[k + i] != 16) begin
          mismatched++;
          $display("FAIL serial_hold%0d: got %0d strobes want 16", i, bits_en_q[k + i + 1] - bits_en_q[k + i]);
        end
      end
    end
    exp_q.delete(); obs_q.delete(); obs_en_q.delete();
  endtask

  task automatic test_resync;
    int r_en;
    logic [9:0] e, o;
    send_sym(-3, 1, 1'b1, 1'b1, 30);
    r_en = en_cnt + 1;
    send_sym(-1, 3, 1'b1, 1'b1, 64);
    compared++;
    if (obs_q.size() != 1) begin
      mismatched++;
      $display("FAIL resync_count: got %0d want 1", obs_q.size());
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      compared++;
      if (o !== e) begin mismatched++; $display("FAIL resync_data: got %h want %h", o, e); end
      compared++;
      if (obs_en_q[0] - r_en != 63) begin
        mismatched++;
        $display("FAIL resync_timing: got %0d want 63", obs_en_q[0] - r_en);
      end
    end
    exp_q.delete(); obs_q.delete(); obs_en_q.delete();
  endtask

  task automatic test_reset_mid_and_ties;
    logic [9:0] e, o;
    logic signed [12:0] x;
    send_sym(1, 1, 1'b1, 1'b0, 40);
    rst = 1'b1;
    step(1'b1, 1'b0, 13'sd100);
    rst = 1'b0;
    compared++;
    if ({SigI, SigQ, Siga, Sigb, sym_valid, bit_out, bit_valid, lock} !== 14'd0) begin
      mismatched++;
      $display("FAIL midrst_outputs: got %h want 0", {SigI, SigQ, Siga, Sigb, sym_valid, bit_out, bit_valid, lock});
    end
    obs_q.delete(); obs_en_q.delete(); exp_q.delete();
    for (int i = 0; i < 70; i++) step(1'b1, 1'b0, 13'sd700);
    compared++;
    if (obs_q.size() != 0) begin
      mismatched++;
      $display("FAIL midrst_idle: sym_valid count %0d want 0", obs_q.size());
    end
    // +/-4088 at phases 0 and 8 puts the I sum exactly on +/-THRESH, Q sum exactly 0.
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 64; n++) begin
        x = (n % 16 == 0) ? 13'sd4088 : (n % 16 == 8) ? -13'sd4088 : 13'sd0;
        if (s == 1) x = -x;
        step(1'b1, (s == 0) && (n == 0), x);
      end
    end
    exp_q.push_back({2'b11, 2'b10, 3'b011, 3'b001});
    exp_q.push_back({2'b01, 2'b10, 3'b111, 3'b001});
    compared++;
    if (obs_q.size() != 2 || lock !== 1'b1) begin
      mismatched++;
      $display("FAIL tie_count: got %0d lock %b want 2 / 1", obs_q.size(), lock);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_en_q.pop_front());
      compared++;
      if (o !== e) begin mismatched++; $display("FAIL tie_sym: got %h want %h", o, e); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_serial;
    test_resync;
    test_reset_mid_and_ties;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
